// File: rtl/race_timer.sv
// Race timer: times one car-selection sequence in BCD ticks and keeps the best
// completed time until reset.
module race_timer #(
   parameter int unsigned TICK_DIV = 5000000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [3:0]  CurState,
   input  logic        Result,
   output logic [15:0] Time_BCD,
   output logic [15:0] Best_BCD,
   output logic        Best_Valid,
   output logic        NewRecord,
   output logic        Finished,
   output logic        Saturated
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   time_q, time_d;
   logic [15:0]   best_q, best_d;
   logic          bestv_q, bestv_d;
   logic          newrec_q, newrec_d;
   logic          fin_q, fin_d;
   logic          sat_q, sat_d;

   // Ripple BCD increment; the caller guarantees the input is below 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      time_d   = time_q;
      best_d   = best_q;
      bestv_d  = bestv_q;
      newrec_d = 1'b0;
      case (state_q)
         IDLE: begin
            time_d = 16'h0000;
            if (CurState == 4'd1) begin
               state_d = RUN;
               presc_d = '0;
            end
         end
         RUN: begin
            // Finish wins over abort, and the finishing cycle does not count.
            if (Result) begin
               state_d = DONE;
               if (!bestv_q || (time_q < best_q)) begin
                  best_d   = time_q;
                  bestv_d  = 1'b1;
                  newrec_d = 1'b1;
               end
            end else if (CurState == 4'd0) begin
               state_d = IDLE;
               time_d  = 16'h0000;
            end else if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               if (time_q != 16'h9999) time_d = bcd_inc(time_q);
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         DONE: begin
            if (CurState == 4'd0) begin
               state_d = IDLE;
               time_d  = 16'h0000;
            end
         end
         default: state_d = IDLE;
      endcase
      fin_d = (state_d == DONE);
      sat_d = (state_d != IDLE) && (time_d == 16'h9999);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         time_q   <= 16'h0000;
         best_q   <= 16'h0000;
         bestv_q  <= 1'b0;
         newrec_q <= 1'b0;
         fin_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         time_q   <= time_d;
         best_q   <= best_d;
         bestv_q  <= bestv_d;
         newrec_q <= newrec_d;
         fin_q    <= fin_d;
         sat_q    <= sat_d;
      end
   end

   assign Time_BCD   = time_q;
   assign Best_BCD   = best_q;
   assign Best_Valid = bestv_q;
   assign NewRecord  = newrec_q;
   assign Finished   = fin_q;
   assign Saturated  = sat_q;

endmodule

// File: doc/race_timer.md
RACE_TIMER -- requirements
Module: race_timer

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clocks per timer tick (0.1 s at 50 MHz); legal range >= 1.
REQ-002 Clock  input  1  single clock; all state updates on posedge Clock.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 CurState  input  4  car-selection FSM state code; 0 = start state A; 1..15 = sequence in progress.
REQ-005 Result  input  1  car-selection FSM finish flag; 1 while that FSM sits in a terminal state.
REQ-006 Time_BCD  output  16  elapsed race time, 4 BCD digits, [15:12] most significant, units of ticks.
REQ-007 Best_BCD  output  16  best (lowest) completed race time, same format.
REQ-008 Best_Valid  output  1  1 once any race has completed since Reset.
REQ-009 NewRecord  output  1  one-cycle pulse when Best_BCD is updated.
REQ-010 Finished  output  1  1 while in DONE.
REQ-011 Saturated  output  1  1 while Time_BCD holds 9999 and the race is running or finished.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-013 IDLE -> RUN SHALL occur only when CurState == 1; a race joined mid-sequence (CurState 2..15) SHALL leave the FSM in IDLE.
REQ-014 On IDLE -> RUN, the prescaler SHALL clear to 0 and Time_BCD SHALL be 0.
REQ-015 In RUN with Result == 0 and CurState != 0, the prescaler SHALL increment each cycle; on reaching TICK_DIV-1 it SHALL wrap to 0 and Time_BCD SHALL increment by 1 in the same edge.
REQ-016 After N such RUN cycles, Time_BCD SHALL equal floor(N/TICK_DIV), BCD-encoded.
REQ-017 BCD increment: each digit 0..9; digit 9 rolls to 0 with carry into next digit (0099 -> 0100, 0999 -> 1000).
REQ-018 At 9999, Time_BCD SHALL hold 9999 (no wrap); Saturated SHALL be 1.
REQ-019 In RUN with Result == 1: no increment that cycle; next state DONE (Result takes priority over CurState).
REQ-020 In RUN with CurState == 0 and Result == 0 (upstream abort): next state IDLE; Time_BCD cleared; Best_* unchanged; no NewRecord.
REQ-021 On RUN -> DONE edge: if Best_Valid == 0 or Time_BCD < Best_BCD, Best_BCD <= Time_BCD, Best_Valid <= 1, NewRecord = 1 for exactly the first DONE cycle; equal time SHALL NOT update or pulse.
REQ-022 In DONE, Time_BCD SHALL hold and Finished SHALL be 1; DONE -> IDLE when CurState == 0, clearing Time_BCD and Saturated.
REQ-023 Best_BCD and Best_Valid SHALL persist across races; only Reset clears them.
REQ-024 Comparison SHALL be on the 16-bit BCD value as unsigned (valid because digits are BCD-ordered).

Reset
REQ-025 Reset SHALL take priority over all other inputs in any state.
REQ-026 After Reset: state IDLE, prescaler 0, Time_BCD = 0, Best_BCD = 0, Best_Valid = 0, NewRecord = 0, Finished = 0, Saturated = 0.
REQ-027 Reset asserted mid-race SHALL discard that race; the FSM then waits in IDLE for CurState == 1.

Verification (TICK_DIV = 4 unless stated)
REQ-028 Reset; CurState 0 -> 1, hold RUN 40 cycles, then Result = 1 -> Time_BCD = 0x0010, Best_BCD = 0x0010, Best_Valid = 1, one NewRecord pulse, Finished = 1.
REQ-029 Return CurState to 0, race 48 cycles -> Time_BCD = 0x0012, Best_BCD stays 0x0010, no pulse; next race 20 cycles -> 0x0005, Best_BCD = 0x0005, pulse; next race 20 cycles -> equal, no pulse.
REQ-030 TICK_DIV = 1, RUN 100 cycles -> 0x0100 (carry chain); RUN 10005 cycles -> 0x9999, Saturated = 1, Best_BCD = 0x9999 on finish.
REQ-031 Race running at 0x0003, CurState forced to 0 -> IDLE next cycle, Time_BCD = 0, Best_* unchanged, Finished = 0.
REQ-032 Reset pulsed in DONE, then CurState = 11 with Result = 1 held -> FSM stays IDLE, all outputs 0; CurState 0 -> 1 starts a new timed race.
REQ-033 CurState = 1 and Result = 1 in the same RUN cycle -> DONE, no increment that cycle.
